// File: rtl/it_state_if.sv
// Instruction-side bundle between the decode stage and the IT-block tracker.
// Decode drives the instruction/qualifier signals; the tracker returns IT status.
interface it_state_if;
  logic        inst_vld;
  logic [15:0] inst;
  logic        it;
  logic [7:0]  cond;
  logic        b;
  logic        flush;
  logic        in_it;
  logic [3:0]  cur_cond;
  logic        last_it;
  logic [2:0]  it_rem;
  logic [7:0]  itstate;
  logic        it_err;

  modport master (
    output inst_vld, inst, it, cond, b, flush,
    input  in_it, cur_cond, last_it, it_rem, itstate, it_err
  );

  modport slave (
    input  inst_vld, inst, it, cond, b, flush,
    output in_it, cur_cond, last_it, it_rem, itstate, it_err
  );
endinterface

// File: rtl/it_state.sv
// Thumb IT-block tracker: holds ITSTATE and reports the condition, position and
// remaining length of the IT block for the instruction retiring this cycle.
module it_state (
  input  logic      clk,
  input  logic      rst_n,
  it_state_if.slave bus
);

  logic [7:0] itstate_q, itstate_d;
  logic       it_err_q, it_err_d;
  logic       in_it;
  logic       last_it;
  logic       legal;
  logic [7:0] adv;
  logic [2:0] it_rem;

  assign in_it   = (itstate_q[3:0] != 4'b0000);
  assign last_it = (itstate_q[3:0] == 4'b1000);
  assign legal   = (bus.cond[3:0] != 4'b0000) && (bus.cond[7:4] != 4'hF);

  // firstcond[3:1] stays put; firstcond[0] and the mask shift together
  assign adv = (itstate_q[2:0] == 3'b000) ? 8'h00
                                          : {itstate_q[7:5], itstate_q[3:0], 1'b0};

  always_comb begin
    it_rem = 3'd0;
    if (itstate_q[0])      it_rem = 3'd4;
    else if (itstate_q[1]) it_rem = 3'd3;
    else if (itstate_q[2]) it_rem = 3'd2;
    else if (itstate_q[3]) it_rem = 3'd1;
  end

  always_comb begin
    itstate_d = itstate_q;
    it_err_d  = 1'b0;
    if (bus.flush) begin
      itstate_d = 8'h00;
    end else if (bus.inst_vld) begin
      if (in_it) begin
        if (bus.it) begin
          // nested IT: abandon the enclosing block rather than load the new one
          it_err_d  = 1'b1;
          itstate_d = 8'h00;
        end else begin
          itstate_d = adv;
          if (bus.b && !last_it) it_err_d = 1'b1;
        end
      end else if (bus.it) begin
        if (legal) itstate_d = bus.cond;
        else       it_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      itstate_q <= 8'h00;
      it_err_q  <= 1'b0;
    end else begin
      itstate_q <= itstate_d;
      it_err_q  <= it_err_d;
    end
  end

  assign bus.in_it    = in_it;
  assign bus.cur_cond = in_it ? itstate_q[7:4] : 4'hE;
  assign bus.last_it  = last_it;
  assign bus.it_rem   = it_rem;
  assign bus.itstate  = itstate_q;
  assign bus.it_err   = it_err_q;

endmodule

// File: tb/tb_it_state.sv
// Directed-vector bench for it_state: table of per-cycle inputs with the
// hand-computed status expected while that instruction is presented.
module tb_it_state;

  typedef struct {
    logic       vld;
    logic       it;
    logic [7:0] cond;
    logic       b;
    logic       flush;
    logic [7:0] e_st;
    logic       e_in;
    logic [3:0] e_cc;
    logic       e_last;
    logic [2:0] e_rem;
    logic       e_err;
  } vec_t;

  logic clk;
  logic rst_n;
  it_state_if bus ();

  it_state dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec;
  int   n_bad;
  vec_t vecs[$];

  function automatic vec_t mk(logic vld, logic it, logic [7:0] cond, logic b, logic flush,
                              logic [7:0] st, logic in_it, logic [3:0] cc, logic last,
                              logic [2:0] rem, logic err);
    vec_t v;
    v.vld = vld; v.it = it; v.cond = cond; v.b = b; v.flush = flush;
    v.e_st = st; v.e_in = in_it; v.e_cc = cc; v.e_last = last; v.e_rem = rem; v.e_err = err;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.inst_vld = v.vld;
    bus.it       = v.it;
    bus.b        = v.b;
    bus.flush    = v.flush;
    if (v.it)     bus.inst = {8'hBF, v.cond};
    else if (v.b) bus.inst = 16'hD000;
    else          bus.inst = 16'h4600;
    bus.cond = v.it ? bus.inst[7:0] : 8'h00;
  endtask

  task automatic check(input string name, input vec_t v);
    n_vec++;
    if (bus.itstate !== v.e_st || bus.in_it !== v.e_in || bus.cur_cond !== v.e_cc ||
        bus.last_it !== v.e_last || bus.it_rem !== v.e_rem || bus.it_err !== v.e_err) begin
      n_bad++;
      $display("FAIL %s: got st=%h in=%b cc=%h last=%b rem=%0d err=%b, want st=%h in=%b cc=%h last=%b rem=%0d err=%b",
               name, bus.itstate, bus.in_it, bus.cur_cond, bus.last_it, bus.it_rem, bus.it_err,
               v.e_st, v.e_in, v.e_cc, v.e_last, v.e_rem, v.e_err);
    end
  endtask

  initial begin
    vec_t idle;
    n_vec = 0;
    n_bad = 0;
    idle  = mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0);

    //          vld it cond   b fl   st     in cc    last rem  err
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0)); // idle
    vecs.push_back(mk(1,1,8'h06,0,0, 8'h00,0,4'hE,0,3'd0,0)); // ITTE EQ
    vecs.push_back(mk(1,0,8'h00,0,0, 8'h06,1,4'h0,0,3'd3,0));
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h0C,1,4'h0,0,3'd2,0)); // bubble
    vecs.push_back(mk(1,0,8'h00,0,0, 8'h0C,1,4'h0,0,3'd2,0));
    vecs.push_back(mk(1,0,8'h00,0,0, 8'h18,1,4'h1,1,3'd1,0));
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'h18,0,0, 8'h00,0,4'hE,0,3'd0,0)); // IT NE
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h18,1,4'h1,1,3'd1,0));
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h18,1,4'h1,1,3'd1,0));
    vecs.push_back(mk(1,0,8'h00,0,0, 8'h18,1,4'h1,1,3'd1,0));
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'h01,0,0, 8'h00,0,4'hE,0,3'd0,0)); // ITTTT EQ
    vecs.push_back(mk(1,0,8'h00,0,0, 8'h01,1,4'h0,0,3'd4,0));
    vecs.push_back(mk(1,0,8'h00,0,0, 8'h02,1,4'h0,0,3'd3,0));
    vecs.push_back(mk(0,0,8'h00,0,1, 8'h04,1,4'h0,0,3'd2,0)); // flush
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'hF4,0,0, 8'h00,0,4'hE,0,3'd0,0)); // illegal firstcond
    vecs.push_back(mk(1,1,8'h30,0,0, 8'h00,0,4'hE,0,3'd0,1)); // illegal mask
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,1));
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'h04,0,0, 8'h00,0,4'hE,0,3'd0,0)); // ITT EQ
    vecs.push_back(mk(1,1,8'h18,0,0, 8'h04,1,4'h0,0,3'd2,0)); // nested IT
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,1));
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'h04,0,0, 8'h00,0,4'hE,0,3'd0,0)); // ITT EQ
    vecs.push_back(mk(1,0,8'h00,1,0, 8'h04,1,4'h0,0,3'd2,0)); // branch first
    vecs.push_back(mk(1,0,8'h00,1,0, 8'h08,1,4'h0,1,3'd1,1)); // branch last
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(0,1,8'h06,0,0, 8'h00,0,4'hE,0,3'd0,0)); // IT without vld
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'hF4,0,1, 8'h00,0,4'hE,0,3'd0,0)); // flushed illegal IT
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'h06,0,1, 8'h00,0,4'hE,0,3'd0,0)); // flushed legal IT
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    vecs.push_back(mk(1,1,8'hA6,0,0, 8'h00,0,4'hE,0,3'd0,0)); // firstcond GE family
    vecs.push_back(mk(1,0,8'h00,0,0, 8'hA6,1,4'hA,0,3'd3,0));
    vecs.push_back(mk(1,0,8'h00,0,0, 8'hAC,1,4'hA,0,3'd2,0));
    vecs.push_back(mk(1,0,8'h00,0,0, 8'hB8,1,4'hB,1,3'd1,0));
    vecs.push_back(mk(0,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));

    rst_n = 1'b0;
    apply(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", idle);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // async reset mid-block with an error pulse pending
    @(posedge clk); #1;
    apply(mk(1,1,8'h01,0,0, 8'h00,0,4'hE,0,3'd0,0));
    @(posedge clk); #1;
    apply(mk(1,0,8'h00,1,0, 8'h00,0,4'hE,0,3'd0,0));
    @(posedge clk); #1;
    apply(idle);
    #2;
    check("pre_reset", mk(0,0,8'h00,0,0, 8'h02,1,4'h0,0,3'd3,1));
    rst_n = 1'b0;
    #1;
    check("async_reset", idle);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk(1,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));
    @(negedge clk);
    check("post_reset", mk(1,0,8'h00,0,0, 8'h00,0,4'hE,0,3'd0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/it_state.md
IT_STATE -- requirements
Module: it_state

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 inst_vld  input  1  current 16-bit instruction is presented this cycle and retires this cycle.
REQ-004 inst  input  16  current Thumb instruction halfword.
REQ-005 it  input  1  ib_chk output; current instruction is an IT instruction.
REQ-006 cond  input  8  ib_chk output; for IT, {firstcond[3:0], mask[3:0]} = inst[7:0].
REQ-007 b  input  1  ib_chk output; current instruction is a branch.
REQ-008 flush  input  1  pipeline flush (taken branch or exception); kills IT block.
REQ-009 in_it  output  1  current instruction lies inside an IT block.
REQ-010 cur_cond  output  4  condition applied to current instruction; 4'hE (AL) when in_it=0.
REQ-011 last_it  output  1  current instruction is last of its IT block.
REQ-012 it_rem  output  3  instructions remaining in block including current, 0..4.
REQ-013 itstate  output  8  architectural ITSTATE register.
REQ-014 it_err  output  1  one-cycle registered pulse flagging an illegal IT usage.

Function
REQ-015 itstate SHALL be the only state besides it_err; in_it, cur_cond, last_it, it_rem SHALL be combinational from itstate and describe the instruction presented in the same cycle.
REQ-016 in_it = (itstate[3:0] != 0); cur_cond = in_it ? itstate[7:4] : 4'hE; last_it = (itstate[3:0] == 4'b1000).
REQ-017 it_rem = 4 - (index of lowest set bit of itstate[3:0]) when in_it, i.e. bit0->4, bit1->3, bit2->2, bit3->1; 0 when in_it=0.
REQ-018 Load: inst_vld=1, it=1, in_it=0, legal -> itstate <= cond next edge (first conditional instruction is the following one).
REQ-019 Legal IT: cond[3:0] != 0 and cond[7:4] != 4'hF.
REQ-020 Advance: inst_vld=1 and in_it=1 and no flush -> if itstate[2:0]==3'b000 then itstate <= 0, else itstate[4:0] <= itstate[4:0] << 1 with itstate[7:5] held.
REQ-021 Idle: inst_vld=0 and flush=0 -> itstate holds; bubbles never consume IT slots.
REQ-022 Priority: flush > load/advance; flush=1 -> itstate <= 0 regardless of inst_vld; it_err not raised by the flushed instruction.
REQ-023 it_err <= 1 for one cycle when, with inst_vld=1 and flush=0: (a) it=1 and illegal per REQ-019; (b) it=1 and in_it=1; (c) b=1 and in_it=1 and last_it=0.
REQ-024 Case (a): itstate stays 0. Case (b): itstate <= 0, nested IT not loaded. Case (c): normal advance per REQ-020.
REQ-025 it=1 with inst_vld=0 SHALL be ignored.
REQ-026 Block sequencing: load cycle N -> in_it=1 for exactly it_rem(N+1) valid instructions, then in_it=0 after the last one retires.

Reset
REQ-027 rst_n=0 SHALL asynchronously force itstate=8'h00, it_err=0; hence in_it=0, cur_cond=4'hE, last_it=0, it_rem=0.
REQ-028 Reset asserted mid-block SHALL abandon the block; first instruction after release is unconditional.
REQ-029 Outputs SHALL be defined (no X) from the first edge after rst_n release with inputs at 0.

Verification
REQ-030 ITTE EQ: inst=16'hBF06, it=1, cond=8'h06 -> next 3 valid cycles itstate=06/0C/18, cur_cond=0/0/1, it_rem=3/2/1, last_it on 3rd, then in_it=0.
REQ-031 IT NE single: cond=8'h18 -> one valid cycle in_it=1, cur_cond=1, last_it=1, it_rem=1; bubbles (inst_vld=0) inserted in between do not advance.
REQ-032 Flush: load cond=8'h01 (ITTTT EQ), flush after 2nd instruction -> itstate=0, in_it=0 next cycle, it_err=0.
REQ-033 Illegal: cond=8'hF4 and cond=8'h30 -> it_err pulses one cycle each, itstate stays 0; IT inside block -> it_err, itstate=0.
REQ-034 Branch: b=1 at 1st of ITT block (cond=8'h04) -> it_err=1, block continues; b=1 at last -> no it_err.
REQ-035 Async reset: assert rst_n=0 mid-clock during block -> outputs at REQ-027 values immediately, before next edge.
